vga_sync_gen: RTL and testbench

VGA 640x480@60 timing generator that drives the frame-buffer read path. Produces active-low hsync/vsync, an active-video flag, and active-area-relative pixel coordinates `h`/`v` consumed by the downstream address translator. Coordinates outside the active window are forced to an out-of-range value, so the translator always blacks out there. Sync and active outputs can be delayed so they stay aligned with the frame-buffer read data.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_sync_gen_sync_delay.sv | 39 +++
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and shared types for vga_sync_gen.
package vga_timing_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 521;
  localparam int unsigned H_PULSE  = 96;
  localparam int unsigned V_PULSE  = 2;
  localparam int unsigned H_BP     = 144;
  localparam int unsigned H_FP     = 784;
  localparam int unsigned V_BP     = 31;
  localparam int unsigned V_FP     = 511;

  localparam int unsigned ACT_WIDTH  = 640;
  localparam int unsigned ACT_HEIGHT = 480;

  // Coordinate value the address translator treats as "blank".
  localparam logic [9:0] COORD_INVALID = 10'h3FF;

  // Signals that travel together through the alignment delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_bundle_t;

  localparam sync_bundle_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_sync_gen_sync_delay.sv
// sync_delay: parameterised-depth shift register with enable and reset value.
// DEPTH of 0 is a straight wire.
module sync_delay #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Advance every stage by one position on each enabled tick.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= RST_VAL;
          end
        end else if (en) begin
          stage[0] <= d;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator feeding the frame-buffer read path.
// Optional build macro VGA_SYNC_PIXEL_DIV2_EN: clk runs at twice the pixel
// rate and an internal toggle flop supplies the pixel tick.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HPIXELS  = H_TOTAL,
  parameter int unsigned VLINES   = V_TOTAL,
  parameter int unsigned HPULSE   = H_PULSE,
  parameter int unsigned VPULSE   = V_PULSE,
  parameter int unsigned HBP      = H_BP,
  parameter int unsigned HFP      = H_FP,
  parameter int unsigned VBP      = V_BP,
  parameter int unsigned VFP      = V_FP,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
  localparam logic [9:0] H_PUL_L = 10'(HPULSE);
  localparam logic [9:0] V_PUL_L = 10'(VPULSE);
  localparam logic [9:0] H_BP_L  = 10'(HBP);
  localparam logic [9:0] H_FP_L  = 10'(HFP);
  localparam logic [9:0] V_BP_L  = 10'(VBP);
  localparam logic [9:0] V_FP_L  = 10'(VFP);

  logic         pix_en;
  logic [9:0]   hc;
  logic [9:0]   vc;
  logic         act;
  sync_bundle_t raw;
  sync_bundle_t dly;

`ifdef VGA_SYNC_PIXEL_DIV2_EN
  // Pixel tick on every second clk; first tick lands on the second edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
    end else begin
      pix_en <= ~pix_en;
    end
  end
`else
  assign pix_en = 1'b1;
`endif

  // Horizontal/vertical position counters, vc steps on the hc wrap tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Active-window decode of the current counter position.
  always_comb begin
    act = (hc >= H_BP_L) && (hc < H_FP_L) && (vc >= V_BP_L) && (vc < V_FP_L);
  end

  // Registered coordinates and raw sync/active, one tick behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h   <= COORD_INVALID;
      v   <= COORD_INVALID;
      raw <= SYNC_IDLE;
    end else if (pix_en) begin
      h          <= act ? hc - H_BP_L : COORD_INVALID;
      v          <= act ? vc - V_BP_L : COORD_INVALID;
      raw.hsync  <= ~(hc < H_PUL_L);
      raw.vsync  <= ~(vc < V_PUL_L);
      raw.active <= act;
    end
  end

  // Clocked every clk, gated by pix_en, so the pulse is one clk wide at either rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= (hc == '0) && (vc == '0) && pix_en;
    end
  end

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .d     (raw),
    .q     (dly)
  );

  assign hsync  = dly.hsync;
  assign vsync  = dly.vsync;
  assign active = dly.active;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two instances (sync delay 0 and 2) share
// clock and reset; a position-based reference model predicts every cycle.
module tb_vga_sync_gen;

  // Horizontal timing at full size, vertical shrunk to keep frames short.
  localparam int H     = 800;
  localparam int HPUL  = 96;
  localparam int HB    = 144;
  localparam int HF    = 784;
  localparam int VL    = 12;
  localparam int VPUL  = 2;
  localparam int VB    = 3;
  localparam int VF    = 10;
  localparam int FRAME = H * VL;
`ifdef VGA_SYNC_PIXEL_DIV2_EN
  localparam int DIVF = 2;
`else
  localparam int DIVF = 1;
`endif

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       fs;
    logic [2:0] s0;   // {hsync, vsync, active} for delay 0
    logic [2:0] s2;   // same for delay 2
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] h0, v0, h2, v2;
  logic       hs0, vs0, act0, fs0, hs2, vs2, act2, fs2;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_edges = 0;   // clk edges with reset released
  int   cyc = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .HPIXELS(H), .VLINES(VL), .HPULSE(HPUL), .VPULSE(VPUL),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .SYNC_DLY(0)
  ) u_d0 (
    .clk(clk), .rst_n(rst_n), .h(h0), .v(v0),
    .hsync(hs0), .vsync(vs0), .active(act0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .HPIXELS(H), .VLINES(VL), .HPULSE(HPUL), .VPULSE(VPUL),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .SYNC_DLY(2)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .h(h2), .v(v2),
    .hsync(hs2), .vsync(vs2), .active(act2), .frame_start(fs2)
  );

  // Sync/active for the screen position reached q ticks after reset (q<0: idle).
  function automatic logic [2:0] sync_at(input int pos);
    int pp, x, y;
    if (pos < 0) return 3'b110;
    pp = pos % FRAME;
    x  = pp % H;
    y  = pp / H;
    return {x >= HPUL, y >= VPUL, (x >= HB && x < HF && y >= VB && y < VF)};
  endfunction

  // Expected outputs after n released clk edges.
  function automatic exp_t model(input int n, input bit in_rst);
    exp_t e;
    int   t, p, x, y;
    bit   tick_edge;
    e.h = 10'h3FF; e.v = 10'h3FF; e.fs = 1'b0; e.s0 = 3'b110; e.s2 = 3'b110;
    if (in_rst) return e;
    t = n / DIVF;
    tick_edge = (n > 0) && (n % DIVF == 0);
    if (t == 0) return e;
    p = (t - 1) % FRAME;
    x = p % H;
    y = p / H;
    if (x >= HB && x < HF && y >= VB && y < VF) begin
      e.h = 10'(x - HB);
      e.v = 10'(y - VB);
    end
    e.fs = tick_edge && (p == 0);
    e.s0 = sync_at(t - 1);
    e.s2 = sync_at(t - 3);
    return e;
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, got, req);
    end
  endtask

  // One clk of stimulus: apply next reset level after the edge, queue expectation.
  task automatic step(input bit rst_next);
    @(posedge clk);
    if (rst_n) n_edges++;
    #1;
    if (!rst_next) n_edges = 0;
    rst_n = rst_next;
    q.push_back(model(n_edges, !rst_n));
  endtask

  // Monitor: compare every cycle plus frame-level spacing/pulse-width checks.
  int last_fs = -1;
  int vs_run  = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dly0", {h0, v0, hs0, vs0, act0, fs0}, {e.h, e.v, e.s0, e.fs});
        check("dly2", {h2, v2, hs2, vs2, act2, fs2}, {e.h, e.v, e.s2, e.fs});
      end
      if (!rst_n) begin
        last_fs = -1;
        vs_run  = 0;
      end else begin
        if (fs0) begin
          if (last_fs >= 0)
            check("fs_spacing", 24'(cyc - last_fs), 24'(FRAME * DIVF));
          last_fs = cyc;
        end
        if (!vs0) begin
          vs_run++;
        end else if (vs_run > 0) begin
          check("vsync_low_len", 24'(vs_run), 24'(VPUL * H * DIVF));
          vs_run = 0;
        end
      end
    end
  end

  initial begin
    int run_len;
    repeat (3) step(1'b0);
    // Two full frames plus margin from a clean release.
    repeat ((2 * FRAME + 40) * DIVF) step(1'b1);
    // Randomly placed mid-frame resets of random length.
    for (int k = 0; k < 4; k++) begin
      run_len = $urandom_range(2500, 50) * DIVF;
      repeat (run_len) step(1'b1);
      repeat ($urandom_range(3, 1)) step(1'b0);
    end
    repeat ((FRAME + 50) * DIVF) step(1'b1);
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
